// File: rtl/conf_loader_if.sv
// Bus bundle of the configuration loader: OBI-style read port toward memory
// and a valid/ready word stream toward the fabric.
interface conf_loader_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        conf_valid_o;
  logic [31:0] conf_data_o;
  logic        conf_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, conf_valid_o, conf_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, conf_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, conf_valid_o, conf_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, conf_ready_i
  );
endinterface

// File: rtl/conf_loader.sv
// Fetches a configuration bitstream from memory on kernel start and streams
// it word by word to the fabric through a small credit-controlled FIFO.
module conf_loader #(
  parameter int unsigned FIFO_DEPTH = 4  // power of two, >= 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          conf_needed_i,
  input  logic [31:0]   conf_addr_i,
  input  logic [15:0]   conf_size_i,
  output logic          conf_done_o,
  output logic          busy_o,
  conf_loader_if.master bus
);

  localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_e;

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_addr;
  logic [15:0]   r_size, r_issued, r_sent;
  logic [CW-1:0] r_outstanding, r_count;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_mem [FIFO_DEPTH];

  logic          w_req, w_gnt, w_push, w_pop, w_empty, w_accept, w_last_pop;
  logic [CW-1:0] w_credit_used;

  assign w_empty       = (r_count == '0);
  assign w_gnt         = w_req & bus.mem_gnt_i;
  // A response with nothing outstanding (stray, or left over from before reset) is dropped.
  assign w_push        = bus.mem_rvalid_i & (r_outstanding != '0);
  assign w_pop         = ~w_empty & bus.conf_ready_i;
  assign w_credit_used = r_outstanding + r_count;
  assign w_accept      = (r_state == S_IDLE) & start_i & conf_needed_i;
  assign w_last_pop    = w_pop & ((r_sent + 16'd1) == r_size);

  assign bus.mem_req_o    = w_req;
  assign bus.mem_addr_o   = r_addr;
  assign bus.conf_valid_o = ~w_empty;
  assign bus.conf_data_o  = w_empty ? '0 : r_mem[r_rptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (conf_size_i == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (w_last_pop) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The credit term never grows without a grant, so a pending request holds until granted.
  always_comb begin
    w_req       = 1'b0;
    conf_done_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE:  busy_o      = 1'b0;
      S_FETCH: w_req       = (r_issued < r_size) && (w_credit_used < DEPTH_C);
      S_DONE:  conf_done_o = 1'b1;
      default: busy_o      = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr        <= '0;
      r_size        <= '0;
      r_issued      <= '0;
      r_sent        <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      if (w_accept && (conf_size_i != '0)) begin
        r_addr   <= conf_addr_i;
        r_size   <= conf_size_i;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (w_gnt) begin
          r_addr   <= r_addr + 32'd4;
          r_issued <= r_issued + 16'd1;
        end
        if (w_pop) r_sent <= r_sent + 16'd1;
      end

      case ({w_gnt, w_push})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: ;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase

      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // NOTE: word storage has no reset; the pointers and count define its contents
  // and conf_data_o is forced to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= bus.mem_rdata_i;
  end

  a_rvalid_expected : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.mem_rvalid_i |-> (r_outstanding != '0)
  ) else $error("conf_loader: mem_rvalid_i with no outstanding read");

endmodule

// File: tb/tb_conf_loader.sv
// Directed bench for conf_loader: pipelined zero-wait memory model with
// optional grant stall, fabric ready control, and per-scenario checks.
module tb_conf_loader;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        conf_needed_i;
  logic [31:0] conf_addr_i;
  logic [15:0] conf_size_i;
  logic        conf_done_o;
  logic        busy_o;

  conf_loader_if ifc();

  conf_loader #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .conf_needed_i(conf_needed_i),
    .conf_addr_i  (conf_addr_i),
    .conf_size_i  (conf_size_i),
    .conf_done_o  (conf_done_o),
    .busy_o       (busy_o),
    .bus          (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  int          done_cnt, busy_cnt, req_cnt, stab_err;
  logic        prev_wait;
  logic [31:0] prev_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory: each grant is answered one cycle later, in order.
  always @(negedge clk) begin
    if (!rst_ni) begin
      mem_q.delete();
      ifc.mem_rvalid_i = 1'b0;
      ifc.mem_rdata_i  = '0;
    end else if (mem_q.size() > 0) begin
      ifc.mem_rvalid_i = 1'b1;
      ifc.mem_rdata_i  = word_at(mem_q.pop_front());
    end else begin
      ifc.mem_rvalid_i = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_ni) begin
      if (ifc.mem_req_o && ifc.mem_gnt_i) begin
        gnt_log.push_back(ifc.mem_addr_o);
        mem_q.push_back(ifc.mem_addr_o);
      end
      if (ifc.conf_valid_o && ifc.conf_ready_i) pop_log.push_back(ifc.conf_data_o);
      if (conf_done_o)   done_cnt++;
      if (busy_o)        busy_cnt++;
      if (ifc.mem_req_o) req_cnt++;
      if (prev_wait && (!ifc.mem_req_o || ifc.mem_addr_o !== prev_addr)) stab_err++;
      prev_wait = ifc.mem_req_o && !ifc.mem_gnt_i;
      prev_addr = ifc.mem_addr_o;
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic clear_logs();
    gnt_log.delete();
    pop_log.delete();
    done_cnt = 0; busy_cnt = 0; req_cnt = 0; stab_err = 0;
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [15:0] s, input logic needed);
    conf_addr_i   = a;
    conf_size_i   = s;
    conf_needed_i = needed;
    start_i       = 1'b1;
    @(negedge clk);
    start_i       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (conf_done_o) seen = 1'b1;
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    logic [31:0] got, exp;
    n_checks++; if (gnt_log.size() != n) begin n_fail++; $display("FAIL %s_ngrant: got %0d expected %0d", tag, gnt_log.size(), n); end
    n_checks++; if (pop_log.size() != n) begin n_fail++; $display("FAIL %s_nword: got %0d expected %0d", tag, pop_log.size(), n); end
    for (int k = 0; k < n; k++) begin
      exp = base + 32'(4 * k);
      got = (k < gnt_log.size()) ? gnt_log[k] : 'x;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL %s_addr[%0d]: got %h expected %h", tag, k, got, exp); end
      exp = word_at(base + 32'(4 * k));
      got = (k < pop_log.size()) ? pop_log[k] : 'x;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL %s_word[%0d]: got %h expected %h", tag, k, got, exp); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (ifc.mem_req_o !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b expected 0", ifc.mem_req_o); end
    n_checks++; if (ifc.conf_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ifc.conf_valid_o); end
    n_checks++; if (conf_done_o !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", conf_done_o); end
    n_checks++; if (busy_o !== 1'b0)           begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (ifc.mem_addr_o !== 32'h0)  begin n_fail++; $display("FAIL reset_addr: got %h expected 0", ifc.mem_addr_o); end
    n_checks++; if (ifc.conf_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", ifc.conf_data_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    bit seen;
    clear_logs();
    ifc.conf_ready_i = 1'b1;
    ifc.mem_gnt_i    = 1'b1;
    conf_addr_i = 32'h1000; conf_size_i = 16'd3; conf_needed_i = 1'b1;
    start_i = 1'b1;
    n_checks++; if (ifc.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL nom_req_early: got %b expected 0", ifc.mem_req_o); end
    @(negedge clk);
    start_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL nom_busy: got %b expected 1", busy_o); end
    wait_done(50, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL nom_timeout: got no conf_done_o expected pulse"); end
    @(negedge clk);
    n_checks++; if (conf_done_o !== 1'b0) begin n_fail++; $display("FAIL nom_done_width: got %b expected 0", conf_done_o); end
    n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL nom_busy_after: got %b expected 0", busy_o); end
    n_checks++; if (done_cnt != 1)        begin n_fail++; $display("FAIL nom_done_cnt: got %0d expected 1", done_cnt); end
    check_stream("nom", 32'h1000, 3);
  endtask

  task automatic test_zero_and_noconf();
    clear_logs();
    drive_start(32'h2000, 16'd0, 1'b1);
    n_checks++; if (conf_done_o !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", conf_done_o); end
    @(negedge clk);
    n_checks++; if (conf_done_o !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", conf_done_o); end
    n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL zero_busy_after: got %b expected 0", busy_o); end
    n_checks++; if (req_cnt != 0)         begin n_fail++; $display("FAIL zero_req_cnt: got %0d expected 0", req_cnt); end
    clear_logs();
    drive_start(32'h2000, 16'd5, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL noconf_busy: got %0d cycles expected 0", busy_cnt); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL noconf_done: got %0d expected 0", done_cnt); end
    n_checks++; if (req_cnt != 0)  begin n_fail++; $display("FAIL noconf_req: got %0d expected 0", req_cnt); end
  endtask

  task automatic test_backpressure();
    bit seen;
    clear_logs();
    ifc.conf_ready_i = 1'b0;
    drive_start(32'h2000, 16'd8, 1'b1);
    repeat (15) @(negedge clk);
    n_checks++; if (gnt_log.size() > 4 || gnt_log.size() == 0) begin n_fail++; $display("FAIL bp_grants: got %0d expected 1..4", gnt_log.size()); end
    n_checks++; if (ifc.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop: got %b expected 0", ifc.mem_req_o); end
    n_checks++; if (ifc.conf_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", ifc.conf_valid_o); end
    repeat (3) @(negedge clk);
    n_checks++; if (ifc.conf_data_o !== word_at(32'h2000)) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", ifc.conf_data_o, word_at(32'h2000)); end
    ifc.conf_ready_i = 1'b1;
    wait_done(100, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout: got no conf_done_o expected pulse"); end
    @(negedge clk);
    check_stream("bp", 32'h2000, 8);
  endtask

  task automatic test_grant_stall();
    bit seen;
    clear_logs();
    ifc.conf_ready_i = 1'b1;
    ifc.mem_gnt_i    = 1'b0;
    drive_start(32'h8000, 16'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (ifc.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected 1", i, ifc.mem_req_o); end
      n_checks++; if (ifc.mem_addr_o !== 32'h8000) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 8000", i, ifc.mem_addr_o); end
      @(negedge clk);
    end
    ifc.mem_gnt_i = 1'b1;
    wait_done(60, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_timeout: got no conf_done_o expected pulse"); end
    @(negedge clk);
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stability: got %0d violations expected 0", stab_err); end
    check_stream("stall", 32'h8000, 4);
  endtask

  task automatic test_wrap_restart();
    bit seen;
    clear_logs();
    ifc.conf_ready_i = 1'b0;
    drive_start(32'hFFFF_FFF8, 16'd3, 1'b1);
    repeat (2) @(negedge clk);
    drive_start(32'h5000, 16'd7, 1'b1);
    ifc.conf_ready_i = 1'b1;
    wait_done(60, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout: got no conf_done_o expected pulse"); end
    repeat (5) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_after: got %b expected 0", busy_o); end
    n_checks++; if (done_cnt != 1)   begin n_fail++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt); end
    check_stream("wrap", 32'hFFFF_FFF8, 3);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n_before;
    clear_logs();
    ifc.conf_ready_i = 1'b1;
    drive_start(32'h3000, 16'd6, 1'b1);
    for (int i = 0; i < 40 && pop_log.size() < 2; i++) @(negedge clk);
    n_before = pop_log.size();
    n_checks++; if (n_before < 2 || n_before >= 6) begin n_fail++; $display("FAIL rmid_progress: got %0d words expected 2..5", n_before); end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (ifc.mem_req_o !== 1'b0)    begin n_fail++; $display("FAIL rmid_req: got %b expected 0", ifc.mem_req_o); end
    n_checks++; if (ifc.conf_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", ifc.conf_valid_o); end
    n_checks++; if (busy_o !== 1'b0)           begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy_o); end
    n_checks++; if (ifc.mem_addr_o !== 32'h0)  begin n_fail++; $display("FAIL rmid_addr: got %h expected 0", ifc.mem_addr_o); end
    n_checks++; if (ifc.conf_data_o !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", ifc.conf_data_o); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0)            begin n_fail++; $display("FAIL rmid_idle_busy: got %b expected 0", busy_o); end
    n_checks++; if (pop_log.size() != n_before) begin n_fail++; $display("FAIL rmid_no_words: got %0d expected %0d", pop_log.size(), n_before); end
    clear_logs();
    drive_start(32'h4000, 16'd2, 1'b1);
    wait_done(40, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_timeout: got no conf_done_o expected pulse"); end
    @(negedge clk);
    check_stream("rmid", 32'h4000, 2);
  endtask

  initial begin
    rst_ni           = 1'b0;
    start_i          = 1'b0;
    conf_needed_i    = 1'b0;
    conf_addr_i      = '0;
    conf_size_i      = '0;
    ifc.mem_gnt_i    = 1'b1;
    ifc.mem_rvalid_i = 1'b0;
    ifc.mem_rdata_i  = '0;
    ifc.conf_ready_i = 1'b0;
    clear_logs();
    prev_wait = 1'b0;
    prev_addr = '0;

    test_reset();
    test_nominal();
    test_zero_and_noconf();
    test_backpressure();
    test_grant_stall();
    test_wrap_restart();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

endmodule

// File: doc/conf_loader.md
CONF_LOADER -- requirements
Module: conf_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: configuration word buffer depth and maximum outstanding reads; power of two, at least 2.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  kernel start pulse, same signal that drives the main control FSM.
REQ-005 conf_needed_i  in  1  high when the fabric holds no valid configuration.
REQ-006 conf_addr_i  in  32  byte base address of the configuration bitstream; word-aligned.
REQ-007 conf_size_i  in  16  bitstream length in 32-bit words.
REQ-008 mem_req_o  out  1  read request, OBI-style.
REQ-009 mem_addr_o  out  32  read address.
REQ-010 mem_gnt_i  in  1  request accepted.
REQ-011 mem_rvalid_i  in  1  read data valid.
REQ-012 mem_rdata_i  in  32  read data.
REQ-013 conf_valid_o  out  1  configuration word available to the fabric.
REQ-014 conf_data_o  out  32  configuration word.
REQ-015 conf_ready_i  in  1  fabric accepts the word.
REQ-016 conf_done_o  out  1  single-cycle pulse when the last word is accepted.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, FETCH, DONE; state is registered.
REQ-019 IDLE->FETCH on start_i=1 with conf_needed_i=1 and conf_size_i!=0; latch conf_addr_i into the address register and conf_size_i into the size register.
REQ-020 IDLE->DONE on start_i=1 with conf_needed_i=1 and conf_size_i=0; no memory access.
REQ-021 start_i with conf_needed_i=0 is ignored in IDLE; conf_done_o stays low.
REQ-022 start_i is ignored outside IDLE; latched address and size stay unchanged.
REQ-023 FETCH: mem_req_o=1 when issued count < size and (outstanding + FIFO occupancy) < FIFO_DEPTH.
REQ-024 mem_req_o rises no earlier than one cycle after the accepting start_i.
REQ-025 Once mem_req_o is high, mem_req_o and mem_addr_o stay stable until the cycle with mem_gnt_i=1.
REQ-026 On each grant: address += 4 (32-bit modulo, wraps 0xFFFFFFFC->0x00000000); issued count += 1; outstanding += 1.
REQ-027 On mem_rvalid_i=1, push mem_rdata_i into the FIFO and decrement outstanding.
REQ-028 Grant and rvalid in the same cycle leave outstanding unchanged.
REQ-029 Credit rule guarantees no FIFO overflow; push and pop in the same cycle on a full FIFO are legal.
REQ-030 Responses arrive in request order; words leave in memory order.
REQ-031 conf_valid_o = FIFO not empty; conf_data_o = FIFO head.
REQ-032 A word pops on conf_valid_o & conf_ready_i; sent count += 1.
REQ-033 conf_data_o holds stable while conf_valid_o=1 and conf_ready_i=0.
REQ-034 FETCH->DONE in the cycle after the pop that makes sent count equal size.
REQ-035 DONE: conf_done_o=1 for exactly one cycle, then DONE->IDLE.
REQ-036 Word counters are 16 bits; size 0xFFFF is fully supported without overflow.
REQ-037 rvalid while outstanding=0 is a protocol error; it is dropped, counters unchanged, and flagged by an assertion.
REQ-038 mem_rvalid_i with no prior grant is never pushed.

Reset
REQ-039 While rst_ni=0: state=IDLE; mem_req_o=0, conf_valid_o=0, conf_done_o=0, busy_o=0; mem_addr_o=0, conf_data_o=0; FIFO empty; all counters 0.
REQ-040 Reset asserted mid-transfer discards buffered words and outstanding reads.
REQ-041 After deassertion the block waits in IDLE for a new start_i.
REQ-042 Responses to reads issued before reset are not pushed.

Verification
REQ-043 Nominal: addr=0x1000, size=3, zero-wait memory, conf_ready_i=1 -> reads at 0x1000, 0x1004, 0x1008; words delivered in order; one conf_done_o pulse; busy_o low the following cycle.
REQ-044 Backpressure: size=8, FIFO_DEPTH=4, conf_ready_i=0 -> no more than 4 grants; mem_req_o drops; after conf_ready_i=1, all 8 words delivered in order.
REQ-045 Zero size and no-conf: size=0, conf_needed_i=1 -> conf_done_o pulses with no mem_req_o; conf_needed_i=0 -> no activity, busy_o stays 0.
REQ-046 Grant stall: mem_gnt_i low for 5 cycles -> mem_addr_o stable through the stall; same-cycle grant/rvalid keeps outstanding correct.
REQ-047 Wrap and re-start: addr=0xFFFFFFF8, size=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; start_i mid-transfer is ignored.
REQ-048 Reset mid-transfer: rst_ni low after 2 of 6 words -> all outputs at reset values; a new start_i completes cleanly.
